instram_arb: RTL and testbench
==============================

Name: instram_arb

Overview:
- Two-requester arbiter and sequencer for the 32 KiB synchronous instruction RAM.
- Port 0 is the Z80 CPU fetch/store path. Port 1 is the boot/ROM loader that fills the RAM.
- The arbiter drives the RAM's read address, write address, rwn and cs. It returns read data and a one-cycle ack per completed access.
- Sits between the CPU bus glue and the instruction RAM in the top level.

Parameters:
- ADDR_W, 15: implemented RAM address bits; addresses with any bit ≥ ADDR_W set are out of range.
- OOR_DATA, 8'hFF: read data returned for an out-of-range read.
- WP_BASE, 16'h0000: first CPU-write-protected address (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  16  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid while cpu_ack=1, else 0
- ld_req  in  1  loader request (level)
- ld_we  in  1  1=write, 0=read
- ld_addr  in  16  loader address
- ld_wdata  in  8  loader write data
- ld_ack  out  1  one-cycle completion pulse
- ld_rdata  out  8  read data, valid while ld_ack=1, else 0
- ram_adr  out  16  RAM read address
- ram_adr_w  out  16  RAM write address, always equal to ram_adr
- ram_rwn  out  1  0=write
- ram_cs  out  1  write strobe qualifier
- ram_din  out  8  RAM write data
- ram_dout  in  8  RAM read data (registered, 1-cycle latency)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset values: cpu_ack=ld_ack=0, rdata outputs 0, ram_cs=0, ram_rwn=1, ram_adr=ram_adr_w=0, ram_din=0. FSM goes to IDLE and the pending-grant register is cleared.
- Reset mid-access: the in-flight access is dropped and no ack is issued. Any write already strobed in the reset cycle still lands in the RAM, because the RAM has no reset.
- FSM states:
  - IDLE: no access in flight.
  - BUSY: an access was issued last cycle; its ack is this cycle.
- Issue (cycle N, state IDLE or BUSY): the arbiter picks a winner combinationally among eligible requests.
  - Eligible = req high and not the port being acked this cycle. The acked port's req is masked for exactly that cycle.
  - Fixed priority: CPU beats loader.
  - Winner's address drives ram_adr/ram_adr_w and its wdata drives ram_din.
  - Write: ram_rwn=0, ram_cs=1. Read: ram_rwn=1, ram_cs=0.
  - Winner id is registered. Next state is BUSY if there is a winner, else IDLE.
- Response (cycle N+1): ack pulses for the registered winner. For a read, that port's rdata = ram_dout. The other port may be issued in the same cycle (back-to-back).
- Throughput: one access per cycle. A single port gets at most one access every 2 cycles.
- Requester rules:
  - Hold addr/we/wdata stable from raising req until ack.
  - May deassert or re-present req in the ack cycle; a re-presented req is considered from the next cycle.
- Out of range (addr[15:ADDR_W] ≠ 0):
  - Write: ram_cs forced 0 (no write), still acked.
  - Read: still acked, rdata = OOR_DATA.
- Simultaneous CPU and loader requests in IDLE: CPU issues at N and is acked at N+1; loader issues at N+1 and is acked at N+2.
- Inactive RAM outputs: when no winner, ram_cs=0 and ram_rwn=1; ram_adr holds its last value.

Optional Feature:
- Macro: INSTRAM_ARB_WP_EN.
- Defined:
  - Adds input wp_en (1) and output cpu_err (1, one-cycle pulse with cpu_ack, reset 0).
  - A CPU write with wp_en=1 and cpu_addr ≥ WP_BASE is suppressed (ram_cs=0), acked, and flags cpu_err=1.
  - Loader writes are never protected.
- Undefined: no extra ports; all in-range writes proceed.

Decomposition:
- Package instram_arb_pkg:
  - state enum {IDLE, BUSY}
  - port index constants PORT_CPU=0, PORT_LD=1
  - default OOR_DATA
- Sub-module instram_arb_pick: combinational eligibility mask plus fixed-priority winner select (inputs: reqs, acked-port mask; outputs: valid, winner id).

Test Plan:
- Single CPU write 8'hA5 to 16'h0123, then a read of 16'h0123 → write: ram_cs=1, ram_rwn=0 in the issue cycle and cpu_ack next cycle. Read: cpu_ack with cpu_rdata=8'hA5 exactly 1 cycle after issue.
- CPU and loader both request reads in the same cycle → cpu_ack at N+1, ld_ack at N+2, no cycle lost between them.
- CPU holds req continuously for 10 accesses while loader requests → acks alternate CPU/loader; loader completes within 2 cycles.
- Loader write to 16'h8000 → ram_cs stays 0, ld_ack pulses, memory unchanged. CPU read of 16'h8000 → cpu_rdata=8'hFF.
- Reset asserted in the cycle after a read issue → no ack, all outputs at reset values; the next request after reset completes normally.
- With INSTRAM_ARB_WP_EN, WP_BASE=16'h4000, wp_en=1: CPU write to 16'h4000 → cpu_err=1, no write. CPU write to 16'h3FFF succeeds. Loader write to 16'h4000 succeeds.

Source files
------------

// File: rtl/instram_arb_pkg.sv
// Shared types and constants for the instruction RAM arbiter.
package instram_arb_pkg;

  // Arbiter sequencing state: BUSY means an access was issued last cycle
  // and its acknowledge is due in the current cycle.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Requester indices; lower index wins under fixed priority.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  // Data returned for a read outside the implemented RAM.
  localparam logic [7:0] DEF_OOR_DATA = 8'hFF;

endpackage

// File: rtl/instram_arb_pick.sv
// Eligibility mask and fixed-priority winner select (CPU over loader).
module instram_arb_pick
  import instram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] acked,
  output logic       valid,
  output logic       win_id
);

  logic [1:0] elig;

  // A port being acknowledged this cycle sits out exactly one cycle.
  always_comb begin
    elig   = req & ~acked;
    valid  = |elig;
    win_id = elig[PORT_CPU] ? PORT_CPU : PORT_LD;
  end

endmodule

// File: rtl/instram_arb.sv
// Two-requester arbiter/sequencer for the 32 KiB instruction RAM.
// Port 0 is the CPU, port 1 is the boot loader. One access issues per
// cycle; its ack (and read data) comes the following cycle.
// Optional macro INSTRAM_ARB_WP_EN adds CPU write protection (wp_en,
// cpu_err, WP_BASE).
module instram_arb
  import instram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 15,
`ifdef INSTRAM_ARB_WP_EN
  parameter logic [15:0] WP_BASE  = 16'h0000,
`endif
  parameter logic [7:0]  OOR_DATA = DEF_OOR_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
`ifdef INSTRAM_ARB_WP_EN
  input  logic        wp_en,
  output logic        cpu_err,
`endif
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  output logic        ld_ack,
  output logic [7:0]  ld_rdata,
  output logic [15:0] ram_adr,
  output logic [15:0] ram_adr_w,
  output logic        ram_rwn,
  output logic        ram_cs,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  state_e      state_q, state_d;
  logic        win_id_q, win_id_d;
  logic        win_we_q, win_we_d;
  logic        win_oor_q, win_oor_d;
  logic [15:0] adr_q, adr_d;
`ifdef INSTRAM_ARB_WP_EN
  logic        win_err_q, win_err_d;
`endif

  logic [1:0]  req_vec;
  logic [1:0]  acked_vec;
  logic        pick_valid;
  logic        pick_id;
  logic        issue;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic        sel_oor;
  logic        wp_hit;
  logic        ack_live;
  logic [7:0]  rdata_src;

  assign req_vec = {ld_req, cpu_req};

  // Mask for the port whose access completes this cycle.
  always_comb begin
    acked_vec = 2'b00;
    acked_vec[win_id_q] = (state_q == BUSY);
  end

  instram_arb_pick u_pick (
    .req    (req_vec),
    .acked  (acked_vec),
    .valid  (pick_valid),
    .win_id (pick_id)
  );

  // Winner mux, range/protection decode and RAM-side drive for the issue cycle.
  always_comb begin
    issue     = pick_valid & ~reset;
    sel_we    = (pick_id == PORT_CPU) ? cpu_we    : ld_we;
    sel_addr  = (pick_id == PORT_CPU) ? cpu_addr  : ld_addr;
    sel_wdata = (pick_id == PORT_CPU) ? cpu_wdata : ld_wdata;
    sel_oor   = (sel_addr >> ADDR_W) != 16'd0;
`ifdef INSTRAM_ARB_WP_EN
    // Only CPU writes are protected; the loader must be able to fill everything.
    wp_hit    = (pick_id == PORT_CPU) & cpu_we & wp_en & (cpu_addr >= WP_BASE);
`else
    wp_hit    = 1'b0;
`endif

    ram_adr   = reset ? 16'h0000 : (issue ? sel_addr : adr_q);
    ram_adr_w = ram_adr;
    ram_din   = issue ? sel_wdata : 8'h00;
    ram_rwn   = ~(issue & sel_we);
    ram_cs    = issue & sel_we & ~sel_oor & ~wp_hit;

    state_d   = issue ? BUSY : IDLE;
    win_id_d  = issue ? pick_id : win_id_q;
    win_we_d  = issue & sel_we;
    win_oor_d = issue & sel_oor;
    adr_d     = issue ? sel_addr : adr_q;
`ifdef INSTRAM_ARB_WP_EN
    win_err_d = issue & wp_hit;
`endif
  end

  // Registered winner record; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      win_id_q  <= PORT_CPU;
      win_we_q  <= 1'b0;
      win_oor_q <= 1'b0;
      adr_q     <= 16'h0000;
`ifdef INSTRAM_ARB_WP_EN
      win_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      win_id_q  <= win_id_d;
      win_we_q  <= win_we_d;
      win_oor_q <= win_oor_d;
      adr_q     <= adr_d;
`ifdef INSTRAM_ARB_WP_EN
      win_err_q <= win_err_d;
`endif
    end
  end

  // Response: ack the registered winner and steer read data to it.
  always_comb begin
    ack_live  = (state_q == BUSY) & ~reset;
    cpu_ack   = ack_live & (win_id_q == PORT_CPU);
    ld_ack    = ack_live & (win_id_q == PORT_LD);
    rdata_src = win_oor_q ? OOR_DATA : ram_dout;
    cpu_rdata = (cpu_ack & ~win_we_q) ? rdata_src : 8'h00;
    ld_rdata  = (ld_ack & ~win_we_q) ? rdata_src : 8'h00;
`ifdef INSTRAM_ARB_WP_EN
    cpu_err   = cpu_ack & win_err_q;
`endif
  end

endmodule

// File: tb/tb_instram_arb.sv
// Directed self-checking bench for instram_arb with a behavioural RAM.
// Define INSTRAM_ARB_WP_EN to also exercise CPU write protection.
module tb_instram_arb;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ld_req, ld_we;
  logic [15:0] ld_addr;
  logic [7:0]  ld_wdata;
  logic        ld_ack;
  logic [7:0]  ld_rdata;
  logic [15:0] ram_adr, ram_adr_w;
  logic        ram_rwn, ram_cs;
  logic [7:0]  ram_din, ram_dout;
`ifdef INSTRAM_ARB_WP_EN
  logic        wp_en;
  logic        cpu_err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:32767];

`ifdef INSTRAM_ARB_WP_EN
  instram_arb #(.ADDR_W(15), .WP_BASE(16'h4000), .OOR_DATA(8'hFF)) dut (
`else
  instram_arb #(.ADDR_W(15), .OOR_DATA(8'hFF)) dut (
`endif
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
`ifdef INSTRAM_ARB_WP_EN
    .wp_en     (wp_en),
    .cpu_err   (cpu_err),
`endif
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .ld_rdata  (ld_rdata),
    .ram_adr   (ram_adr),
    .ram_adr_w (ram_adr_w),
    .ram_rwn   (ram_rwn),
    .ram_cs    (ram_cs),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: write on rwn=0 & cs=1, registered read.
  always @(posedge clk) begin
    if (ram_cs && !ram_rwn) mem[ram_adr_w[14:0]] <= ram_din;
    ram_dout <= mem[ram_adr[14:0]];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cpu_cnt;
    int ld_cnt;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    ld_req = 0;  ld_we = 0;  ld_addr = 16'h0;  ld_wdata = 8'h0;
`ifdef INSTRAM_ARB_WP_EN
    wp_en = 1'b0;
`endif
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    nxt(); nxt();

    // Reset values
    mid();
    chk("rst_cpu_ack", cpu_ack, 0);   chk("rst_ld_ack", ld_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0); chk("rst_ld_rdata", ld_rdata, 0);
    chk("rst_cs", ram_cs, 0);  chk("rst_rwn", ram_rwn, 1);
    chk("rst_adr", ram_adr, 0); chk("rst_adr_w", ram_adr_w, 0);
    chk("rst_din", ram_din, 0);
    nxt();
    reset = 1'b0;

    // CPU write A5 -> 0123
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0123; cpu_wdata = 8'hA5;
    mid();
    chk("wr_cs", ram_cs, 1);   chk("wr_rwn", ram_rwn, 0);
    chk("wr_adr", ram_adr, 16'h0123); chk("wr_adr_w", ram_adr_w, 16'h0123);
    chk("wr_din", ram_din, 8'hA5); chk("wr_noack", cpu_ack, 0);
    nxt();
    cpu_req = 0;
    mid();
    chk("wr_ack", cpu_ack, 1); chk("wr_idle_cs", ram_cs, 0);
    chk("wr_idle_rwn", ram_rwn, 1); chk("wr_hold_adr", ram_adr, 16'h0123);
    nxt();

    // CPU read 0123
    cpu_req = 1; cpu_we = 0;
    mid();
    chk("rd_rwn", ram_rwn, 1); chk("rd_cs", ram_cs, 0); chk("rd_noack", cpu_ack, 0);
    nxt();
    cpu_req = 0;
    mid();
    chk("rd_ack", cpu_ack, 1); chk("rd_data", cpu_rdata, 8'hA5);
    nxt();
    mid();
    chk("rd_ack_clr", cpu_ack, 0); chk("rd_data_clr", cpu_rdata, 0);
    nxt();

    // Loader write 3C -> 0200
    ld_req = 1; ld_we = 1; ld_addr = 16'h0200; ld_wdata = 8'h3C;
    mid();
    chk("ldwr_cs", ram_cs, 1); chk("ldwr_adr", ram_adr, 16'h0200); chk("ldwr_din", ram_din, 8'h3C);
    nxt();
    ld_req = 0;
    mid();
    chk("ldwr_ack", ld_ack, 1); chk("ldwr_cpu_noack", cpu_ack, 0);
    nxt();

    // Simultaneous reads: CPU first, loader back-to-back
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0123;
    ld_req = 1;  ld_we = 0;  ld_addr = 16'h0200;
    mid();
    chk("sim_adr0", ram_adr, 16'h0123); chk("sim_noack", {cpu_ack, ld_ack}, 0);
    nxt();
    cpu_req = 0;
    mid();
    chk("sim_cpu_ack", cpu_ack, 1); chk("sim_cpu_data", cpu_rdata, 8'hA5);
    chk("sim_ld_noack", ld_ack, 0); chk("sim_adr1", ram_adr, 16'h0200);
    nxt();
    ld_req = 0;
    mid();
    chk("sim_ld_ack", ld_ack, 1); chk("sim_ld_data", ld_rdata, 8'h3C);
    chk("sim_cpu_ack2", cpu_ack, 0);
    nxt();

    // Both hold req: acks alternate CPU / loader
    cpu_req = 1; ld_req = 1;
    mid();
    nxt();
    cpu_cnt = 0; ld_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 20) begin cpu_req = 0; ld_req = 0; end
      mid();
      chk($sformatf("alt_cpu_%0d", k), cpu_ack, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("alt_ld_%0d", k), ld_ack, (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 1) chk($sformatf("alt_cpu_data_%0d", k), cpu_rdata, 8'hA5);
      else            chk($sformatf("alt_ld_data_%0d", k), ld_rdata, 8'h3C);
      if (cpu_ack) cpu_cnt++;
      if (ld_ack)  ld_cnt++;
      nxt();
    end
    mid();
    chk("alt_quiet", {cpu_ack, ld_ack}, 0);
    chk("alt_cpu_cnt", cpu_cnt[15:0], 10); chk("alt_ld_cnt", ld_cnt[15:0], 10);
    nxt();

    // Out-of-range loader write and CPU read
    ld_req = 1; ld_we = 1; ld_addr = 16'h8000; ld_wdata = 8'h77;
    mid();
    chk("oor_wr_cs", ram_cs, 0); chk("oor_wr_adr", ram_adr, 16'h8000);
    nxt();
    ld_req = 0;
    mid();
    chk("oor_wr_ack", ld_ack, 1);
    nxt();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h8000;
    mid();
    nxt();
    cpu_req = 0;
    mid();
    chk("oor_rd_ack", cpu_ack, 1); chk("oor_rd_data", cpu_rdata, 8'hFF);
    nxt();
    cpu_req = 1; cpu_addr = 16'h0000;
    mid();
    nxt();
    cpu_req = 0;
    mid();
    chk("oor_mem_unchanged", cpu_rdata, 8'h00); chk("oor_mem_ack", cpu_ack, 1);
    nxt();

    // Reset in the cycle after a read issue
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0123;
    mid();
    nxt();
    cpu_req = 0; reset = 1;
    mid();
    chk("mid_rst_ack", cpu_ack, 0); chk("mid_rst_rdata", cpu_rdata, 0);
    chk("mid_rst_cs", ram_cs, 0); chk("mid_rst_rwn", ram_rwn, 1);
    chk("mid_rst_adr", ram_adr, 0); chk("mid_rst_din", ram_din, 0);
    nxt();
    reset = 0;
    mid();
    chk("post_rst_noack", cpu_ack, 0); chk("post_rst_adr", ram_adr, 0);
    nxt();
    cpu_req = 1; cpu_addr = 16'h0200;
    mid();
    nxt();
    cpu_req = 0;
    mid();
    chk("post_rst_ack", cpu_ack, 1); chk("post_rst_data", cpu_rdata, 8'h3C);
    nxt();

`ifdef INSTRAM_ARB_WP_EN
    // Write protection above 4000 for CPU writes only
    wp_en = 1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h4000; cpu_wdata = 8'h11;
    mid();
    chk("wp_cs", ram_cs, 0);
    nxt();
    cpu_req = 0;
    mid();
    chk("wp_ack", cpu_ack, 1); chk("wp_err", cpu_err, 1);
    nxt();
    mid();
    chk("wp_err_clr", cpu_err, 0);
    nxt();
    cpu_req = 1; cpu_addr = 16'h3FFF; cpu_wdata = 8'h22;
    mid();
    chk("wp_below_cs", ram_cs, 1);
    nxt();
    cpu_req = 0;
    mid();
    chk("wp_below_ack", cpu_ack, 1); chk("wp_below_err", cpu_err, 0);
    nxt();
    ld_req = 1; ld_we = 1; ld_addr = 16'h4000; ld_wdata = 8'h33;
    mid();
    chk("wp_ld_cs", ram_cs, 1);
    nxt();
    ld_req = 0;
    mid();
    chk("wp_ld_ack", ld_ack, 1); chk("wp_ld_err", cpu_err, 0);
    nxt();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4000;
    mid();
    nxt();
    cpu_req = 0;
    mid();
    chk("wp_rd_data", cpu_rdata, 8'h33); chk("wp_rd_err", cpu_err, 0);
    nxt();
    wp_en = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
